argmax_comparator: RTL and testbench
====================================

# argmax_comparator

Streaming argmax unit for the classifier output stage. It accepts NUM_CLASSES neuron scores one per handshake, compares each against a running maximum, and reports the winning class index and its score. It sits after the final neuron layer and drives the prediction register. It generalises the single-pair 8-bit equality check to parametrised-width magnitude comparison over a full vector, with sequencing and handshaking.

## Interface
- DATA_W, 8, width of each score
- NUM_CLASSES, 10, scores per frame (>= 2)
- IDX_W, 4, index width; must satisfy 2^IDX_W >= NUM_CLASSES
- clk  input  1  rising-edge clock
- rst  input  1  reset; the only clock is clk, and rst is synchronous and active-high
- start  input  1  begin a frame; sampled only in IDLE
- in_valid  input  1  in_data carries a score
- in_data  input  DATA_W  score for the current class index
- in_ready  output  1  unit accepts a score this cycle
- busy  output  1  frame in progress (RUN or DONE)
- done  output  1  one-cycle pulse: result valid
- max_idx  output  IDX_W  index of the maximum score
- max_val  output  DATA_W  maximum score

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=0, busy=0. start=1 goes to RUN next cycle. It also clears cnt, cur_max and cur_idx to 0 and sets a first-element flag.
- RUN: in_ready=1, busy=1. An element is accepted when in_valid && in_ready.
  - First accepted element: loaded unconditionally (cur_max=in_data, cur_idx=0).
  - Later elements: replace the running maximum only if in_data > cur_max (strict). Ties keep the lower index.
  - The index stored is the current cnt. cnt increments on every accept.
- When the accept with cnt==NUM_CLASSES-1 occurs, go to DONE next cycle.
- DONE: one cycle. done=1, in_ready=0, busy=1. max_idx and max_val are copied from cur_idx and cur_max on the DONE entry edge. Next state is IDLE.
- max_idx and max_val hold their values until the next DONE or rst.
- in_valid=0 in RUN stalls the unit without a timeout. Bubbles are allowed anywhere in a frame.
- start is ignored in RUN and DONE. A start asserted during DONE is not queued; it must be reasserted in IDLE.
- rst in any state, including mid-frame, takes effect on the next edge:
  - state goes to IDLE and all internal registers clear;
  - any partial frame is discarded and no done pulse is produced.

## Timing
- Reset values: in_ready=0, busy=0, done=0, max_idx=0, max_val=0.
- start is sampled at edge T0. in_ready rises in cycle T0+1.
- With in_valid held high, the last element is accepted at edge T0+NUM_CLASSES. done is high in the following cycle, and results are valid in the same cycle as done.
- Start-to-done: NUM_CLASSES+1 cycles, plus stall cycles.
- Minimum spacing between frames: back-to-back start is accepted in the first IDLE cycle after DONE. Frame period is NUM_CLASSES+2 cycles.
- The comparison is single-cycle combinational on registered cur_max. No pipelining.

## Configuration
- ARGMAX_SIGNED_EN
  - Defined: in_data, cur_max and max_val are treated as two's-complement, and comparison is signed.
  - Undefined (default): comparison is unsigned.
  - Everything else is unchanged.

## Test plan
- Unsigned, NUM_CLASSES=10: scores 3,7,1,200,5,9,0,2,4,6 with in_valid held high. Required: done one cycle after the 10th accept, max_idx=3, max_val=200.
- Tie: scores 5,9,9,1,... (rest 0). Required: max_idx=1, max_val=9 (lowest index wins). All-equal 42: max_idx=0.
- Bubbles: same vector as the first scenario with in_valid deasserted every other cycle. Required: identical result, with done delayed by exactly the number of bubble cycles.
- rst mid-frame: rst asserted after 4 accepts. Required: next cycle in_ready=0, busy=0, max_idx=0, max_val=0, no done pulse. A following full frame gives the correct result.
- Ignored start: start pulsed in RUN and in DONE. Required: no restart and the frame completes normally. start in IDLE immediately after DONE begins a new frame, and the result registers hold until its done.
- ARGMAX_SIGNED_EN defined, DATA_W=8: scores 0x80 (-128), 0x7F, 0xFF, rest 0x00. Required: max_idx=1, max_val=0x7F. Unsigned build on the same vector: max_idx=2, max_val=0xFF.

Source files
------------

// File: rtl/argmax_comparator_if.sv
// Handshake and result bundle for the streaming argmax unit.
interface argmax_comparator_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) ();
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  max_idx;
  logic [DATA_W-1:0] max_val;

  modport master (output start, in_valid, in_data,
                  input  in_ready, busy, done, max_idx, max_val);
  modport slave  (input  start, in_valid, in_data,
                  output in_ready, busy, done, max_idx, max_val);
endinterface

// File: rtl/argmax_comparator.sv
// Streaming argmax over NUM_CLASSES scores; reports winning index and score.
// Define ARGMAX_SIGNED_EN to compare scores as two's-complement.
module argmax_comparator #(
  parameter int DATA_W      = 8,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  argmax_comparator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, nxt;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_max;
  logic              first;
  logic              accept;
  logic              last;
  logic              gt;
  logic              take;
  logic [IDX_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_val;

  assign accept = (state == RUN) && bus.in_valid;
  assign last   = (cnt == IDX_W'(NUM_CLASSES - 1));

`ifdef ARGMAX_SIGNED_EN
  assign gt = $signed(bus.in_data) > $signed(cur_max);
`else
  assign gt = bus.in_data > cur_max;
`endif

  // Strict compare keeps the lower index on ties.
  assign take    = first || gt;
  assign win_idx = take ? cnt         : cur_idx;
  assign win_val = take ? bus.in_data : cur_max;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = RUN;
      RUN:     if (accept && last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_idx     <= '0;
      cur_max     <= '0;
      first       <= 1'b0;
      bus.max_idx <= '0;
      bus.max_val <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (bus.start) begin
          cnt     <= '0;
          cur_idx <= '0;
          cur_max <= '0;
          first   <= 1'b1;
        end
        RUN: if (accept) begin
          cur_idx <= win_idx;
          cur_max <= win_val;
          cnt     <= cnt + 1'b1;
          first   <= 1'b0;
          // Forward the final element so the result is ready with done.
          if (last) begin
            bus.max_idx <= win_idx;
            bus.max_val <= win_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = (state == RUN);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_argmax_comparator.sv
// Directed bench for argmax_comparator: unsigned/signed vectors, ties, bubbles, reset, ignored start.
module tb_argmax_comparator;

  typedef logic [7:0] vec_t [10];

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  argmax_comparator_if #(.DATA_W(8), .IDX_W(4)) bus ();
  argmax_comparator #(.DATA_W(8), .NUM_CLASSES(10), .IDX_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Runs one frame starting in the current (IDLE) cycle; returns in the DONE cycle.
  task automatic send_frame(input vec_t s, input bit bub, input int mid_start,
                            input logic [3:0] hold_idx, input logic [7:0] hold_val,
                            output int cyc, output bit early_done, output bit hold_ok);
    early_done = 1'b0;
    hold_ok    = 1'b1;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (bub && i > 0) begin
        bus.in_valid = 1'b0;
        if (bus.done !== 1'b0) early_done = 1'b1;
        step();
        cyc++;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      if (i == mid_start) bus.start = 1'b1;
      if (bus.done !== 1'b0 || bus.in_ready !== 1'b1) early_done = 1'b1;
      if (bus.max_idx !== hold_idx || bus.max_val !== hold_val) hold_ok = 1'b0;
      step();
      cyc++;
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  vec_t v_main, v_tie, v_eq, v_sgn;
  int   cyc;
  bit   early, hold;

  initial begin
    v_main = '{8'd3, 8'd7, 8'd1, 8'd200, 8'd5, 8'd9, 8'd0, 8'd2, 8'd4, 8'd6};
    v_tie  = '{8'd5, 8'd9, 8'd9, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    v_eq   = '{default: 8'd42};
    v_sgn  = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    rst = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    step(); step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy",     bus.busy,     0);
    chk("rst_done",     bus.done,     0);
    chk("rst_max_idx",  bus.max_idx,  0);
    chk("rst_max_val",  bus.max_val,  0);
    rst = 1'b0;
    step();

    // Main unsigned vector, in_valid held high
    send_frame(v_main, 1'b0, -1, 4'd0, 8'd0, cyc, early, hold);
    chk("main_no_early_done", early, 0);
    chk("main_hold",          hold,  1);
    chk("main_latency",       cyc,   10);
    chk("main_done",          bus.done,    1);
    chk("main_busy_done",     bus.busy,    1);
    chk("main_ready_done",    bus.in_ready, 0);
    chk("main_idx",           bus.max_idx, 3);
    chk("main_val",           bus.max_val, 200);
    step();
    chk("main_done_pulse",    bus.done, 0);
    chk("main_idle_busy",     bus.busy, 0);
    chk("main_hold_idx",      bus.max_idx, 3);

    // Tie: lowest index wins; back-to-back start in first IDLE cycle
    send_frame(v_tie, 1'b0, -1, 4'd3, 8'd200, cyc, early, hold);
    chk("tie_hold_prev",      hold, 1);
    chk("tie_latency",        cyc, 10);
    chk("tie_done",           bus.done, 1);
    chk("tie_idx",            bus.max_idx, 1);
    chk("tie_val",            bus.max_val, 9);
    step();

    send_frame(v_eq, 1'b0, -1, 4'd1, 8'd9, cyc, early, hold);
    chk("eq_done",            bus.done, 1);
    chk("eq_idx",             bus.max_idx, 0);
    chk("eq_val",             bus.max_val, 42);
    step();

    // Bubbles between every element: done delayed by 9 cycles
    send_frame(v_main, 1'b1, -1, 4'd0, 8'd42, cyc, early, hold);
    chk("bub_no_early_done",  early, 0);
    chk("bub_latency",        cyc, 19);
    chk("bub_done",           bus.done, 1);
    chk("bub_idx",            bus.max_idx, 3);
    chk("bub_val",            bus.max_val, 200);
    step();

    // Reset after 4 accepts
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = v_main[i]; step();
    end
    rst = 1'b1; bus.in_data = 8'd250; step();
    rst = 1'b0; bus.in_valid = 1'b1;
    chk("mrst_in_ready",      bus.in_ready, 0);
    chk("mrst_busy",          bus.busy, 0);
    chk("mrst_idx",           bus.max_idx, 0);
    chk("mrst_val",           bus.max_val, 0);
    early = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) early = 1'b1;
      step();
    end
    chk("mrst_no_done",       early, 0);
    bus.in_valid = 1'b0;
    send_frame(v_main, 1'b0, -1, 4'd0, 8'd0, cyc, early, hold);
    chk("mrst_frame_done",    bus.done, 1);
    chk("mrst_frame_idx",     bus.max_idx, 3);
    chk("mrst_frame_val",     bus.max_val, 200);
    step();

    // start in RUN and DONE is ignored
    send_frame(v_tie, 1'b0, 5, 4'd3, 8'd200, cyc, early, hold);
    chk("ign_no_early_done",  early, 0);
    chk("ign_latency",        cyc, 10);
    chk("ign_done",           bus.done, 1);
    chk("ign_idx",            bus.max_idx, 1);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("ign_idle_busy",      bus.busy, 0);
    chk("ign_idle_ready",     bus.in_ready, 0);
    step();
    chk("ign_still_idle",     bus.busy, 0);

    // Signed vs unsigned interpretation
    send_frame(v_sgn, 1'b0, -1, 4'd1, 8'd9, cyc, early, hold);
    chk("sgn_done",           bus.done, 1);
`ifdef ARGMAX_SIGNED_EN
    chk("sgn_idx",            bus.max_idx, 1);
    chk("sgn_val",            bus.max_val, 8'h7F);
`else
    chk("sgn_idx",            bus.max_idx, 2);
    chk("sgn_val",            bus.max_val, 8'hFF);
`endif
    step();
    chk("final_idle",         bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
